// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite read-path types and constants
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef logic mid_t;

    localparam mid_t MID_ICACHE = 1'b0;
    localparam mid_t MID_LSU    = 1'b1;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// rtl/axi_read_arbiter_if.sv - AXI4-Lite read address/data channel bundle
interface axi_read_arbiter_if #(
    parameter int WIDTH = 32
);

    logic             arvalid;
    logic             arready;
    logic [WIDTH-1:0] araddr;
    logic             rvalid;
    logic             rready;
    logic [WIDTH-1:0] rdata;
    logic [1:0]       rresp;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin selector, one-hot grant
module rr_pick2
    import axi_lite_pkg::*;
(
    input  logic [1:0] req,
    input  mid_t       last_grant,
    output logic [1:0] grant
);

    // On a tie the master that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || last_grant == MID_LSU)) begin
            grant[0] = 1'b1;
        end else if (req[1]) begin
            grant[1] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - icache/LSU round-robin arbiter for one AXI4-Lite read port
module axi_read_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                clock,
    input  logic                reset,
    axi_read_arbiter_if.slave   m0,
    axi_read_arbiter_if.slave   m1,
    axi_read_arbiter_if.master  s,
    output logic                timeout_o
);

    import axi_lite_pkg::*;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e       state;
    mid_t             owner;
    mid_t             last_grant;
    logic [WIDTH-1:0] araddr_q;
    logic [CW-1:0]    wd_count;
    logic [1:0]       grant;
    logic             r_done;

    rr_pick2 u_pick (
        .req        ({m1.arvalid, m0.arvalid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign m0.arready = (state == ARB_IDLE) && grant[0];
    assign m1.arready = (state == ARB_IDLE) && grant[1];

    assign s.arvalid = (state == ARB_ADDR);
    assign s.araddr  = araddr_q;
    assign s.rready  = (state == ARB_DATA) && ((owner == MID_LSU) ? m1.rready : m0.rready);

    // Response payload is broadcast; only the owner sees rvalid.
    assign m0.rvalid = (state == ARB_DATA) && (owner == MID_ICACHE) && s.rvalid;
    assign m1.rvalid = (state == ARB_DATA) && (owner == MID_LSU) && s.rvalid;
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;
    assign m0.rresp  = s.rresp;
    assign m1.rresp  = s.rresp;

    assign r_done = s.rvalid && s.rready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= MID_ICACHE;
            last_grant <= MID_LSU;
            araddr_q   <= '0;
            wd_count   <= '0;
            timeout_o  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|grant) begin
                        araddr_q <= grant[1] ? m1.araddr : m0.araddr;
                        owner    <= grant[1] ? MID_LSU : MID_ICACHE;
                        state    <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (s.arready) begin
                        wd_count <= '0;
                        state    <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (r_done) begin
                        last_grant <= owner;
                        state      <= ARB_IDLE;
                    end else begin
                        // Watchdog only flags; the transaction keeps waiting.
                        if (wd_count != WD_LIMIT) begin
                            wd_count <= wd_count + 1'b1;
                        end
                        if (TIMEOUT != 0 && wd_count == WD_LAST) begin
                            timeout_o <= 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
